nave_controle: RTL and testbench

- Player-side counterpart of the enemy row: owns the player ship and its single shot.
- Produces the ship position and the player-bullet coordinates that the enemy row consumes (bola_nave_x/y, x_nave/y_nave).
- Consumes the enemy row's status outputs: hit count (reg_n_batidas) and ship-killed flag (reg_naveMorta).
- Keeps lives and score, and raises fim_jogo. Single clock domain; a movement tick is derived internally.

---
 rtl/jogo_pkg.sv | 25 ++
 rtl/nave_controle_gerador_tick.sv | 27 ++
 rtl/nave_controle.sv | 177 +++++++++++++++++
 tb/tb_nave_controle.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the single-clock game logic: FSM encodings,
// screen geometry and the parked-coordinate marker.
package jogo_pkg;

  typedef enum logic [1:0] {
    NAVE_VIVA  = 2'd0,
    NAVE_MORTA = 2'd1,
    NAVE_FIM   = 2'd2
  } nave_estado_t;

  typedef enum logic {
    BOLA_LIVRE  = 1'b0,
    BOLA_VOANDO = 1'b1
  } bola_estado_t;

  localparam int unsigned TELA_LARG        = 640;
  localparam int unsigned TELA_ALT         = 480;
  localparam logic [9:0]  COORD_FORA       = 10'd1023;
  localparam int unsigned NAVE_LARG_PADRAO = 33;

  function automatic logic [9:0] x_centro(input int unsigned larg);
    return 10'((TELA_LARG - larg) / 2);
  endfunction

endpackage

// File: rtl/nave_controle_gerador_tick.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles;
// the count freezes while en_i is low.
module gerador_tick #(
  parameter int unsigned DIV = 833333
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] ULT = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == ULT) ? '0 : cnt_q + W'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == ULT);

endmodule

// File: rtl/nave_controle.sv
// Player ship and its single shot: movement, firing, hit scoring, lives and
// game-over. All buttons are synchronized; enemy-row status is same-domain.
module nave_controle
  import jogo_pkg::*;
#(
  parameter int unsigned MV_DIV      = 833333,
  parameter int unsigned NAVE_PASSO  = 4,
  parameter int unsigned BOLA_PASSO  = 8,
  parameter int unsigned NAVE_LARG   = NAVE_LARG_PADRAO,
  parameter int unsigned NAVE_Y      = 440,
  parameter int unsigned VIDAS_INI   = 3,
  parameter int unsigned MORTA_TICKS = 60
) (
  input  logic       CLOCK_50_i,
  input  logic       reset_i,
  input  logic       pausa_i,
  input  logic       reiniciarJogo_i,
  input  logic       btn_esq_i,
  input  logic       btn_dir_i,
  input  logic       btn_tiro_i,
  input  logic [1:0] n_batidas_i,
  input  logic       naveMorta_i,
  output logic [9:0] x_nave_o,
  output logic [9:0] y_nave_o,
  output logic [9:0] bola_nave_x_o,
  output logic [9:0] bola_nave_y_o,
  output logic       bola_ativa_o,
  output logic [1:0] vidas_o,
  output logic [9:0] pontos_o,
  output logic       fim_jogo_o
);

  localparam logic [9:0] X_INI      = x_centro(NAVE_LARG);
  localparam logic [9:0] X_MIN      = 10'd5;
  localparam logic [9:0] X_MAX      = 10'(TELA_LARG - NAVE_LARG);
  localparam logic [9:0] N_PASSO    = 10'(NAVE_PASSO);
  localparam logic [9:0] B_PASSO    = 10'(BOLA_PASSO);
  localparam logic [9:0] Y_NAVE     = 10'(NAVE_Y);
  localparam logic [9:0] Y_BOLA_INI = 10'(NAVE_Y - 8);
  localparam logic [9:0] BOLA_DX    = 10'((NAVE_LARG - 1) / 2);
  localparam logic [9:0] Y_LIMITE   = 10'(TELA_ALT);
  localparam int unsigned MW        = $clog2(MORTA_TICKS + 1);
  localparam logic [MW-1:0] MORTE_INI = MW'(MORTA_TICKS);
  localparam logic [1:0] VIDAS0     = 2'(VIDAS_INI);

  logic rst_jogo_n;
  logic tick;

  logic esq_s1_q, esq_s2_q, dir_s1_q, dir_s2_q;
  logic tiro_s1_q, tiro_s2_q, tiro_ant_q, morta_ant_q;
  logic [1:0] nb_ant_q;

  nave_estado_t nave_q;
  bola_estado_t bola_q;
  logic [9:0] x_q, bx_q, by_q, pontos_q;
  logic [1:0] vidas_q;
  logic       fim_q;
  logic [MW-1:0] morte_cnt_q;

  logic tiro_borda, morte_evt, acerto;
  logic [9:0] x_esq_d, x_dir_d, pontos_d;

  // Restart behaves exactly like reset, so both feed one synchronous clear.
  assign rst_jogo_n = reset_i & ~reiniciarJogo_i;

  gerador_tick #(.DIV(MV_DIV)) u_tick (
    .clk_i  (CLOCK_50_i),
    .rst_ni (rst_jogo_n),
    .en_i   (~pausa_i),
    .tick_o (tick)
  );

  assign tiro_borda = tiro_s2_q & ~tiro_ant_q & ~pausa_i;
  assign morte_evt  = naveMorta_i & ~morta_ant_q & ~pausa_i & (nave_q == NAVE_VIVA);
  assign acerto     = (n_batidas_i != nb_ant_q) & (bola_q == BOLA_VOANDO) & ~pausa_i;

  // Clamp checks happen before the step so 10-bit arithmetic never wraps.
  assign x_esq_d  = (x_q < X_MIN + N_PASSO) ? X_MIN : x_q - N_PASSO;
  assign x_dir_d  = (x_q > X_MAX - N_PASSO) ? X_MAX : x_q + N_PASSO;
  assign pontos_d = (pontos_q == 10'h3FF) ? pontos_q : pontos_q + 10'd1;

  always_ff @(posedge CLOCK_50_i) begin
    if (!rst_jogo_n) begin
      esq_s1_q    <= 1'b0;
      esq_s2_q    <= 1'b0;
      dir_s1_q    <= 1'b0;
      dir_s2_q    <= 1'b0;
      tiro_s1_q   <= 1'b0;
      tiro_s2_q   <= 1'b0;
      tiro_ant_q  <= 1'b0;
      morta_ant_q <= naveMorta_i;
      nb_ant_q    <= n_batidas_i;
      nave_q      <= NAVE_VIVA;
      bola_q      <= BOLA_LIVRE;
      x_q         <= X_INI;
      bx_q        <= COORD_FORA;
      by_q        <= COORD_FORA;
      vidas_q     <= VIDAS0;
      pontos_q    <= '0;
      fim_q       <= 1'b0;
      morte_cnt_q <= '0;
    end else begin
      esq_s1_q    <= btn_esq_i;
      esq_s2_q    <= esq_s1_q;
      dir_s1_q    <= btn_dir_i;
      dir_s2_q    <= dir_s1_q;
      tiro_s1_q   <= btn_tiro_i;
      tiro_s2_q   <= tiro_s1_q;
      tiro_ant_q  <= tiro_s2_q;
      morta_ant_q <= naveMorta_i;

      if (!pausa_i) begin
        nb_ant_q <= n_batidas_i;

        unique case (nave_q)
          NAVE_VIVA: begin
            if (morte_evt) begin
              nave_q      <= NAVE_MORTA;
              vidas_q     <= vidas_q - 2'd1;
              morte_cnt_q <= MORTE_INI;
            end else if (tick && (esq_s2_q ^ dir_s2_q)) begin
              x_q <= esq_s2_q ? x_esq_d : x_dir_d;
            end
          end
          NAVE_MORTA: begin
            if (tick) begin
              if (morte_cnt_q == '0) begin
                if (vidas_q == 2'd0) begin
                  nave_q <= NAVE_FIM;
                  fim_q  <= 1'b1;
                end else begin
                  nave_q <= NAVE_VIVA;
                  x_q    <= X_INI;
                end
              end else begin
                morte_cnt_q <= morte_cnt_q - MW'(1);
              end
            end
          end
          default: ;
        endcase

        // A hit or a death parks the shot; a hit also scores even on a top exit.
        if (acerto || morte_evt) begin
          bola_q <= BOLA_LIVRE;
          bx_q   <= COORD_FORA;
          by_q   <= COORD_FORA;
          if (acerto) pontos_q <= pontos_d;
        end else if (bola_q == BOLA_LIVRE) begin
          if (tiro_borda && (nave_q == NAVE_VIVA)) begin
            bola_q <= BOLA_VOANDO;
            bx_q   <= x_q + BOLA_DX;
            by_q   <= Y_BOLA_INI;
          end
        end else if (tick) begin
          if ((by_q < B_PASSO) || (by_q >= Y_LIMITE)) begin
            bola_q <= BOLA_LIVRE;
            bx_q   <= COORD_FORA;
            by_q   <= COORD_FORA;
          end else begin
            by_q <= by_q - B_PASSO;
          end
        end
      end
    end
  end

  assign x_nave_o      = x_q;
  assign y_nave_o      = Y_NAVE;
  assign bola_nave_x_o = bx_q;
  assign bola_nave_y_o = by_q;
  assign bola_ativa_o  = (bola_q == BOLA_VOANDO);
  assign vidas_o       = vidas_q;
  assign pontos_o      = pontos_q;
  assign fim_jogo_o    = fim_q;

endmodule

// File: tb/tb_nave_controle.sv
// Directed bench for nave_controle with a fast tick (4 cycles) and a short
// death period; movement via a vector table, the rest as hand sequences.
module tb_nave_controle;

  logic       clk = 1'b0;
  logic       reset_i, pausa_i, reiniciarJogo_i;
  logic       btn_esq_i, btn_dir_i, btn_tiro_i, naveMorta_i;
  logic [1:0] n_batidas_i;
  logic [9:0] x_nave_o, y_nave_o, bola_nave_x_o, bola_nave_y_o, pontos_o;
  logic       bola_ativa_o, fim_jogo_o;
  logic [1:0] vidas_o;

  int n_ok  = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  nave_controle #(.MV_DIV(4), .MORTA_TICKS(3)) dut (
    .CLOCK_50_i      (clk),
    .reset_i         (reset_i),
    .pausa_i         (pausa_i),
    .reiniciarJogo_i (reiniciarJogo_i),
    .btn_esq_i       (btn_esq_i),
    .btn_dir_i       (btn_dir_i),
    .btn_tiro_i      (btn_tiro_i),
    .n_batidas_i     (n_batidas_i),
    .naveMorta_i     (naveMorta_i),
    .x_nave_o        (x_nave_o),
    .y_nave_o        (y_nave_o),
    .bola_nave_x_o   (bola_nave_x_o),
    .bola_nave_y_o   (bola_nave_y_o),
    .bola_ativa_o    (bola_ativa_o),
    .vidas_o         (vidas_o),
    .pontos_o        (pontos_o),
    .fim_jogo_o      (fim_jogo_o)
  );

  typedef struct {
    logic  esq;
    logic  dir;
    int    ticks;
    int    x_exp;
    string nome;
  } mov_t;

  mov_t tab[8];

  task automatic chk(input string nome, input int act, input int exp);
    n_tot++;
    if (act == exp) n_ok++;
    else $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press fire and wait (bounded) for the shot to appear; step lands on the launch edge.
  task automatic lancar(input string nome);
    int i;
    i = 0;
    btn_tiro_i = 1'b1;
    step(1);
    while (!bola_ativa_o && i < 10) begin
      step(1);
      i++;
    end
    btn_tiro_i = 1'b0;
    chk(nome, int'(bola_ativa_o), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{1'b0, 1'b1,  10, 343, "mov_dir10"};
    tab[1] = '{1'b0, 1'b1, 100, 607, "mov_dir_sat"};
    tab[2] = '{1'b0, 1'b0,   5, 607, "mov_none"};
    tab[3] = '{1'b1, 1'b1,   5, 607, "mov_both"};
    tab[4] = '{1'b1, 1'b0,  10, 567, "mov_esq10"};
    tab[5] = '{1'b1, 1'b0, 200,   5, "mov_esq_sat"};
    tab[6] = '{1'b0, 1'b1,   1,   9, "mov_dir_from_min"};
    tab[7] = '{1'b1, 1'b0,   1,   5, "mov_esq_to_min"};

    reset_i = 1'b0; pausa_i = 1'b0; reiniciarJogo_i = 1'b0;
    btn_esq_i = 1'b0; btn_dir_i = 1'b0; btn_tiro_i = 1'b0;
    naveMorta_i = 1'b0; n_batidas_i = 2'd0;
    step(2);
    reset_i = 1'b1;
    step(1);

    chk("rst_x",      x_nave_o,      303);
    chk("rst_y_nave", y_nave_o,      440);
    chk("rst_bx",     bola_nave_x_o, 1023);
    chk("rst_by",     bola_nave_y_o, 1023);
    chk("rst_ativa",  bola_ativa_o,  0);
    chk("rst_vidas",  vidas_o,       3);
    chk("rst_pontos", pontos_o,      0);
    chk("rst_fim",    fim_jogo_o,    0);

    // Flight to the top, with a second press mid-flight that must be ignored.
    lancar("fire1_launch");
    chk("fire1_bx", bola_nave_x_o, 319);
    chk("fire1_by", bola_nave_y_o, 432);
    step(80);
    chk("fly20_by", bola_nave_y_o, 272);
    btn_tiro_i = 1'b1;
    step(4);
    btn_tiro_i = 1'b0;
    step(4);
    chk("fly22_by", bola_nave_y_o, 256);
    chk("fly22_bx_refire", bola_nave_x_o, 319);
    step(128);
    chk("fly54_by",    bola_nave_y_o, 0);
    chk("fly54_ativa", bola_ativa_o,  1);
    step(4);
    chk("exit_ativa", bola_ativa_o,  0);
    chk("exit_bx",    bola_nave_x_o, 1023);
    chk("exit_by",    bola_nave_y_o, 1023);

    // Hit scoring, and counter changes while no shot is flying.
    n_batidas_i = 2'd2;
    step(3);
    chk("nb_livre_pre", pontos_o, 0);
    lancar("fire2_launch");
    step(4);
    n_batidas_i = 2'd3;
    step(1);
    chk("hit_ativa",  bola_ativa_o,  0);
    chk("hit_by",     bola_nave_y_o, 1023);
    chk("hit_pontos", pontos_o,      1);
    n_batidas_i = 2'd0;
    step(3);
    chk("nb_livre_post", pontos_o, 1);

    for (int i = 0; i < 8; i++) begin
      btn_esq_i = tab[i].esq;
      btn_dir_i = tab[i].dir;
      step(4 * tab[i].ticks);
      btn_esq_i = 1'b0;
      btn_dir_i = 1'b0;
      step(4);
      chk(tab[i].nome, x_nave_o, tab[i].x_exp);
    end

    // Pause with a shot at y=200 and right held.
    lancar("fire3_launch");
    chk("fire3_bx", bola_nave_x_o, 21);
    step(116);
    chk("pre_pause_by", bola_nave_y_o, 200);
    pausa_i = 1'b1;
    step(2);
    btn_dir_i = 1'b1;
    step(200);
    chk("pause_by",    bola_nave_y_o, 200);
    chk("pause_x",     x_nave_o,      5);
    chk("pause_ativa", bola_ativa_o,  1);
    pausa_i = 1'b0;
    step(18);
    btn_dir_i = 1'b0;
    step(2);
    chk("resume_x",  x_nave_o,      25);
    chk("resume_by", bola_nave_y_o, 160);
    step(100);
    chk("resume_exit", bola_ativa_o, 0);

    pausa_i = 1'b1;
    step(1);
    btn_tiro_i = 1'b1;
    step(4);
    btn_tiro_i = 1'b0;
    step(4);
    pausa_i = 1'b0;
    step(10);
    chk("pause_fire_dropped", bola_ativa_o, 0);

    // First death with a shot in flight; naveMorta held through the death period.
    lancar("fire4_launch");
    naveMorta_i = 1'b1;
    step(1);
    chk("death1_vidas", vidas_o,       2);
    chk("death1_ativa", bola_ativa_o,  0);
    chk("death1_bx",    bola_nave_x_o, 1023);
    btn_tiro_i = 1'b1;
    step(3);
    btn_tiro_i = 1'b0;
    step(3);
    chk("morta_fire_ignored", bola_ativa_o, 0);
    step(40);
    chk("revive_x",        x_nave_o, 303);
    chk("held_no_retrig",  vidas_o,  2);
    naveMorta_i = 1'b0;
    step(2);

    naveMorta_i = 1'b1;
    step(2);
    naveMorta_i = 1'b0;
    step(1);
    chk("death2_vidas", vidas_o, 1);
    step(40);

    naveMorta_i = 1'b1;
    step(2);
    naveMorta_i = 1'b0;
    step(1);
    chk("death3_vidas", vidas_o,    0);
    chk("death3_fim0",  fim_jogo_o, 0);
    step(40);
    chk("fim_set", fim_jogo_o, 1);

    btn_dir_i  = 1'b1;
    btn_tiro_i = 1'b1;
    step(40);
    chk("fim_x_frozen",  x_nave_o,     303);
    chk("fim_no_fire",   bola_ativa_o, 0);
    chk("fim_sticky",    fim_jogo_o,   1);
    btn_dir_i  = 1'b0;
    btn_tiro_i = 1'b0;
    step(4);

    reiniciarJogo_i = 1'b1;
    step(1);
    reiniciarJogo_i = 1'b0;
    step(1);
    chk("restart_vidas",  vidas_o,       3);
    chk("restart_fim",    fim_jogo_o,    0);
    chk("restart_pontos", pontos_o,      0);
    chk("restart_x",      x_nave_o,      303);
    chk("restart_bx",     bola_nave_x_o, 1023);

    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
